// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate format codes and RV opcode constants shared by the immediate stage
package imm_gen_pkg;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// imm_decode: combinational instruction+pc to immediate, format and PC-relative target
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] target
);
  logic [6:0]  op;
  logic [31:0] imm32;
  fmt_e        f;
  assign op = instr[6:0];
  always_comb begin
    f = (op == OP_IMM || op == OP_LOAD || op == OP_JALR) ? FMT_I :
        (op == OP_STORE)                                 ? FMT_S :
        (op == OP_BRANCH)                                ? FMT_B :
        (op == OP_LUI || op == OP_AUIPC)                 ? FMT_U :
        (op == OP_JAL)                                   ? FMT_J :
        (op == OP_SYSTEM && instr[14])                   ? FMT_Z : FMT_NONE;
    imm32 = (f == FMT_I) ? {{20{instr[31]}}, instr[31:20]} :
            (f == FMT_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            (f == FMT_B) ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
            (f == FMT_U) ? {instr[31:12], 12'b0} :
            (f == FMT_J) ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
            (f == FMT_Z) ? {27'b0, instr[19:15]} : 32'b0;
  end
  assign imm    = XLEN'($signed(imm32));
  assign fmt    = f;
  assign target = pc + ((f == FMT_B || f == FMT_J || op == OP_AUIPC) ? imm : XLEN'(4));
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage with valid/ready handshake and 2-entry skid
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter bit SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_target,
  output logic [TAG_W-1:0] out_tag
);
  localparam int E = 2 * XLEN + 3 + TAG_W;
  logic [XLEN-1:0] dec_imm, dec_target;
  logic [2:0]      dec_fmt;
  logic [E-1:0]    dec_e, main_q, skid_q;
  logic            skid_valid, accept, drain;
  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .imm   (dec_imm),
    .fmt   (dec_fmt),
    .target(dec_target)
  );
  assign dec_e    = {dec_imm, dec_fmt, dec_target, in_tag};
  assign {out_imm, out_fmt, out_target, out_tag} = main_q;
  assign in_ready = SKID_EN ? !skid_valid : (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (drain || !out_valid) begin
        out_valid <= skid_valid || accept;
        if (skid_valid) main_q <= skid_q;
        else if (accept) main_q <= dec_e;
      end
      if (drain) skid_valid <= 1'b0;
      else if (accept && out_valid) begin
        skid_valid <= 1'b1;
        skid_q     <= dec_e;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed vector and handshake-sequence checks for imm_gen_stage at XLEN 32 and 64
module tb_imm_gen_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic [63:0] pc64 = '0;
  logic [3:0]  in_tag = '0;
  logic        rdy32, val32, rdy64, val64;
  logic [31:0] imm32, tgt32;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt32, fmt64;
  logic [3:0]  tag32, tag64;
  int checks = 0, fails = 0;
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
  } vec_t;
  vec_t v[12];
  always #5 clk = ~clk;
  imm_gen_stage #(.XLEN(32), .TAG_W(4), .SKID_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(pc64[31:0]), .in_tag(in_tag), .out_valid(val32),
    .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32), .out_tag(tag32)
  );
  imm_gen_stage #(.XLEN(64), .TAG_W(4), .SKID_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(pc64), .in_tag(in_tag), .out_valid(val64),
    .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64), .out_tag(tag64)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_valid32"}, val32, 0);
    chk({name, "_ready32"}, rdy32, 1);
    chk({name, "_imm32"}, imm32, 0);
    chk({name, "_fmt32"}, fmt32, 0);
    chk({name, "_tgt32"}, tgt32, 0);
    chk({name, "_tag32"}, tag32, 0);
    chk({name, "_valid64"}, val64, 0);
    chk({name, "_imm64"}, imm64, 0);
    chk({name, "_tgt64"}, tgt64, 0);
  endtask
  initial begin
    int sent, got, seen;
    v[0]  = '{32'hFFF00093, 64'h200,      3'd1, 64'hFFFFFFFFFFFFFFFF, 64'h204};
    v[1]  = '{32'hFE000EE3, 64'h100,      3'd3, 64'hFFFFFFFFFFFFFFFC, 64'h0FC};
    v[2]  = '{32'h800002B7, 64'h300,      3'd4, 64'hFFFFFFFF80000000, 64'h304};
    v[3]  = '{32'h0010006F, 64'h1000,     3'd5, 64'h800,              64'h1800};
    v[4]  = '{32'h0007D073, 64'h40,       3'd6, 64'h0F,               64'h44};
    v[5]  = '{32'hFE512C23, 64'h10,       3'd2, 64'hFFFFFFFFFFFFFFF8, 64'h14};
    v[6]  = '{32'h00001517, 64'h2000,     3'd4, 64'h1000,             64'h3000};
    v[7]  = '{32'hFFDFF06F, 64'h0,        3'd5, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
    v[8]  = '{32'h00B50533, 64'h500,      3'd0, 64'h0,                64'h504};
    v[9]  = '{32'h34011073, 64'h600,      3'd0, 64'h0,                64'h604};
    v[10] = '{32'hFFC08067, 64'h80,       3'd1, 64'hFFFFFFFFFFFFFFFC, 64'h84};
    v[11] = '{32'h00B50533, 64'hFFFFFFFC, 3'd0, 64'h0,                64'h100000000};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_pre_valid", i), val32, 0);
      in_valid = 1'b1;
      in_instr = v[i].instr;
      pc64     = v[i].pc;
      in_tag   = 4'(i);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid32", i), val32, 1);
      chk($sformatf("v%0d_imm32", i), imm32, 64'(v[i].imm[31:0]));
      chk($sformatf("v%0d_fmt32", i), fmt32, 64'(v[i].fmt));
      chk($sformatf("v%0d_tgt32", i), tgt32, 64'(v[i].tgt[31:0]));
      chk($sformatf("v%0d_tag32", i), tag32, 64'(i));
      chk($sformatf("v%0d_imm64", i), imm64, v[i].imm);
      chk($sformatf("v%0d_fmt64", i), fmt64, 64'(v[i].fmt));
      chk($sformatf("v%0d_tgt64", i), tgt64, v[i].tgt);
    end
    sent = 0;
    got  = 0;
    in_instr = 32'h00100093;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 3);
      in_valid  = (sent < 4);
      in_tag    = 4'(sent + 1);
      pc64      = 64'(sent * 4);
      if (c == 2) begin
        chk("stream_in_ready_low", rdy32, 0);
        chk("stream_sent_before_stall", sent, 2);
        chk("stream_hold_tag", tag32, 1);
      end
      if (val32 && out_ready) begin
        chk($sformatf("stream_order%0d", got), tag32, 64'(got + 1));
        got++;
      end
      if (in_valid && rdy32) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("stream_got", got, 4);
    chk("stream_empty", val32, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 4'd5;
    @(negedge clk);
    in_tag = 4'd6;
    @(negedge clk);
    chk("flush_full_ready", rdy32, 0);
    chk("flush_full_valid", val32, 1);
    in_tag = 4'd7;
    flush  = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid32", val32, 0);
    chk("flush_ready32", rdy32, 1);
    chk("flush_valid64", val64, 0);
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (val32) seen++;
    end
    chk("flush_dropped", seen, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 4'd8;
    @(negedge clk);
    chk("flush1_ready", rdy32, 1);
    in_tag = 4'd9;
    flush  = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush1_valid", val32, 0);
    out_ready = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (val32) seen++;
    end
    chk("flush1_dropped", seen, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    pc64      = 64'h200;
    in_tag    = 4'd10;
    @(negedge clk);
    in_tag = 4'd11;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_stall_valid", val32, 1);
    chk("rst_stall_tag", tag32, 10);
    rst   = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    chk_zero("midrst");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
